store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart of the load word/half/byte selector.
- Takes a CPU store (address, register data, size selects w/h/b) and produces word-wide memory writes to a data memory that has no byte enables.
- Word stores are written directly; half and byte stores are done as read-modify-write (RMW) with a handshake on both the CPU and memory sides.
- Sits between the MEM stage and the data-memory port.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ack per access before aborting with st_err. Range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req  in  1  store request. Sampled only in IDLE.
- st_addr  in  32  byte address of store.
- st_data  in  32  store data. Byte uses [7:0], half uses [15:0].
- w  in  1  word store select.
- h  in  1  halfword store select.
- b  in  1  byte store select.
- st_busy  out  1  high in every state except IDLE.
- st_done  out  1  one-cycle pulse when the store completes.
- st_err  out  1  one-cycle pulse on misalignment, invalid size or timeout.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_rd  out  1  read strobe. Held until mem_ack.
- mem_wr  out  1  write strobe. Held until mem_ack.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data. Valid in the cycle mem_ack is high.
- mem_ack  in  1  memory acknowledge. Single-cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers and timeout counter 0.
- Reset asserted mid-operation aborts immediately. No st_done or st_err is issued for the aborted store.
- All outputs are registered. States: IDLE, READ, WRITE, DONE, ERR.
- IDLE, st_req high: latch st_addr, st_data and size; then take the first matching case:
  - size not exactly one-hot in {w,h,b} -> ERR.
  - w with addr[1:0] != 0 -> ERR.
  - h with addr[0] = 1 -> ERR.
  - w -> WRITE, with mem_wdata = st_data.
  - h or b -> READ.
- Lane mapping is little-endian:
  - byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - half at addr[1] = 0 occupies [15:0]; at addr[1] = 1 it occupies [31:16].
- READ:
  - mem_rd = 1, mem_addr = word address.
  - On mem_ack: merged = mem_rdata with the selected lane(s) replaced by the low byte/half of the latched data; mem_wdata = merged; go to WRITE.
- WRITE:
  - mem_wr = 1, same mem_addr.
  - On mem_ack -> DONE.
- DONE: st_done = 1 for one cycle -> IDLE.
- ERR: st_err = 1 for one cycle -> IDLE. No mem_rd or mem_wr is ever asserted for an erroring request.
- Timeout counter:
  - Cleared on entry to READ and to WRITE; increments each cycle without mem_ack.
  - Reaching TIMEOUT -> drop strobe -> ERR.
  - mem_ack arriving in the same cycle the count reaches TIMEOUT wins: the access completes normally.
- mem_rd and mem_wr are never high together. Strobes drop in the cycle after ack.
- Latency with zero-wait memory (ack in first strobe cycle):
  - word: req at cycle 0, mem_wr at cycle 1, st_done at cycle 2.
  - half/byte: mem_rd at cycle 1, mem_wr at cycle 2, st_done at cycle 3.
- st_req while busy is ignored. The CPU holds the request until it sees st_done or st_err.
- Upper bits of st_data beyond the store size are ignored.

Test Plan:
- Memory word 0x100 = 0xf0f0f0f0. sb addr 0x103, data 0x123456AB -> one read, write 0xABf0f0f0 to 0x100; st_done at cycle 3.
- Same word. sh addr 0x102, data 0xFFFF1234 -> write 0x1234f0f0. sh addr 0x100 -> write 0xf0f01234.
- sw addr 0x100, data 0xdeadbeef -> no mem_rd; mem_wr at cycle 1 with 0xdeadbeef; st_done at cycle 2.
- sh addr 0x101; sw addr 0x102; w=h=1 -> each gives st_err one-cycle pulse, mem_rd = mem_wr = 0 throughout, back to IDLE.
- TIMEOUT=4, memory never acks on sb -> mem_rd held 4 cycles, st_err pulse, no write. Repeat with 3 wait states -> completes with st_done.
- Assert rst during WRITE of sb -> mem_wr drops asynchronously, no st_done. Next sw after reset completes normally.

Source files
------------

// File: rtl/store_merge_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : store_merge_unit_if
// Brief    : CPU-store and word-memory signal bundle for store_merge_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface store_merge_unit_if;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        w;
    logic        h;
    logic        b;
    logic        st_busy;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Design-side view: accepts CPU stores, drives the memory port.
    modport slave (
        input  st_req, st_addr, st_data, w, h, b, mem_rdata, mem_ack,
        output st_busy, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    // Environment view: CPU plus data memory.
    modport master (
        output st_req, st_addr, st_data, w, h, b, mem_rdata, mem_ack,
        input  st_busy, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_merge_unit
// Brief    : Turns word/half/byte CPU stores into word-wide memory writes,
//            using read-modify-write for sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module store_merge_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    store_merge_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [7:0]  w_next_cnt;
    logic [7:0]  w_cnt_inc;
    logic [1:0]  r_lane;
    logic [15:0] r_data;
    logic        r_half;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_onehot;
    logic        w_bad;
    logic [31:0] w_merged;

    // Request legality, evaluated only when a request is sampled in IDLE.
    always_comb begin
        w_onehot = ({bus.w, bus.h, bus.b} == 3'b100) ||
                   ({bus.w, bus.h, bus.b} == 3'b010) ||
                   ({bus.w, bus.h, bus.b} == 3'b001);
        w_bad    = !w_onehot ||
                   (bus.w && (bus.st_addr[1:0] != 2'b00)) ||
                   (bus.h && bus.st_addr[0]);
    end

    // Little-endian lane insertion of the latched store data into the read word.
    always_comb begin
        w_merged = bus.mem_rdata;
        if (r_half) begin
            if (r_lane[1]) begin
                w_merged[31:16] = r_data;
            end else begin
                w_merged[15:0]  = r_data;
            end
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end
    end

    // Next-state and wait counter. An ack in the final permitted cycle wins.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_cnt_inc    = r_cnt + 8'd1;
        case (r_state)
            S_IDLE: begin
                if (bus.st_req) begin
                    w_next_cnt = 8'd0;
                    if (w_bad) begin
                        w_next_state = S_ERR;
                    end else if (bus.w) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.mem_ack) begin
                    w_next_state = S_WRITE;
                    w_next_cnt   = 8'd0;
                end else begin
                    w_next_cnt = w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        w_next_state = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (bus.mem_ack) begin
                    w_next_state = S_DONE;
                    w_next_cnt   = 8'd0;
                end else begin
                    w_next_cnt = w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        w_next_state = S_ERR;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State plus outputs registered from the next state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_busy   <= (w_next_state != S_IDLE);
            r_done   <= (w_next_state == S_DONE);
            r_err    <= (w_next_state == S_ERR);
            r_mem_rd <= (w_next_state == S_READ);
            r_mem_wr <= (w_next_state == S_WRITE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane      <= 2'd0;
            r_data      <= 16'd0;
            r_half      <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && bus.st_req) begin
                r_lane     <= bus.st_addr[1:0];
                r_data     <= bus.st_data[15:0];
                r_half     <= bus.h;
                r_mem_addr <= {bus.st_addr[31:2], 2'b00};
                if (bus.w) begin
                    r_mem_wdata <= bus.st_data;
                end
            end else if ((r_state == S_READ) && bus.mem_ack) begin
                r_mem_wdata <= w_merged;
            end
        end
    end

    assign bus.st_busy   = r_busy;
    assign bus.st_done   = r_done;
    assign bus.st_err    = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_merge_unit
// Brief    : Directed self-checking bench with a cycle-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_merge_unit;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_merge_unit_if bus();

    store_merge_unit #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } snap_t;

    snap_t       exp_q[$];
    bit          model_off = 1'b0;
    logic [31:0] mem [logic [31:0]];
    int          wait_states = 0;
    bit          no_ack = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Memory: acks a held strobe after wait_states extra cycles unless no_ack.
    initial begin
        int waited;
        waited = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!(bus.mem_rd || bus.mem_wr)) begin
                waited = 0;
            end else if (!no_ack) begin
                if (waited == wait_states) begin
                    bus.mem_ack = 1'b1;
                    waited = 0;
                    if (bus.mem_rd) bus.mem_rdata = mem[bus.mem_addr];
                    else            mem[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    waited++;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the expected timeline.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (!model_off) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = '0;
                chk("st_busy", 32'(bus.st_busy), 32'(e.busy));
                chk("st_done", 32'(bus.st_done), 32'(e.done));
                chk("st_err",  32'(bus.st_err),  32'(e.err));
                chk("mem_rd",  32'(bus.mem_rd),  32'(e.rd));
                chk("mem_wr",  32'(bus.mem_wr),  32'(e.wr));
                if (e.rd || e.wr) chk("mem_addr", bus.mem_addr, e.addr);
                if (e.wr)         chk("mem_wdata", bus.mem_wdata, e.wdata);
            end
        end
    end

    // Expected outputs, cycle 0 (request cycle) onward, from the store rules.
    task automatic plan(input logic w_, input logic h_, input logic b_,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ws, input bit na);
        snap_t       s;
        int          acc;
        int          sh;
        bit          tmo;
        bit          bad;
        logic [31:0] wa;
        logic [31:0] mask;
        logic [31:0] merged;
        exp_q.push_back('0);
        bad = ((int'(w_) + int'(h_) + int'(b_)) != 1) ||
              (w_ && (a[1:0] != 2'b00)) || (h_ && a[0]);
        if (bad) begin
            s = '0; s.busy = 1'b1; s.err = 1'b1;
            exp_q.push_back(s);
            return;
        end
        wa  = {a[31:2], 2'b00};
        tmo = na || (ws + 1 > TMO);
        acc = tmo ? TMO : ws + 1;
        if (w_) begin
            merged = d;
        end else begin
            s = '0; s.busy = 1'b1; s.rd = 1'b1; s.addr = wa;
            repeat (acc) exp_q.push_back(s);
            if (tmo) begin
                s = '0; s.busy = 1'b1; s.err = 1'b1;
                exp_q.push_back(s);
                return;
            end
            if (h_) begin
                sh   = 8 * int'(a[1:0] & 2'b10);
                mask = 32'h0000FFFF << sh;
                merged = (mem[wa] & ~mask) | ((d & 32'h0000FFFF) << sh);
            end else begin
                sh   = 8 * int'(a[1:0]);
                mask = 32'h000000FF << sh;
                merged = (mem[wa] & ~mask) | ((d & 32'h000000FF) << sh);
            end
        end
        s = '0; s.busy = 1'b1; s.wr = 1'b1; s.addr = wa; s.wdata = merged;
        repeat (acc) exp_q.push_back(s);
        s = '0; s.busy = 1'b1;
        if (tmo) s.err = 1'b1; else s.done = 1'b1;
        exp_q.push_back(s);
    endtask

    // Called just after a rising edge with the DUT idle; returns cycles to done/err.
    task automatic do_store(input logic w_, input logic h_, input logic b_,
                            input logic [31:0] a, input logic [31:0] d,
                            input int ws, input bit na,
                            output int lat, output bit ok);
        wait_states = ws;
        no_ack      = na;
        plan(w_, h_, b_, a, d, ws, na);
        bus.st_req  = 1'b1;
        bus.w       = w_;
        bus.h       = h_;
        bus.b       = b_;
        bus.st_addr = a;
        bus.st_data = d;
        lat = 0;
        ok  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.st_done || bus.st_err) begin
                lat = k;
                ok  = bus.st_done;
                break;
            end
        end
        if (lat == 0) begin
            n_total++;
            $display("FAIL store_no_response: got none expected st_done/st_err addr 0x%08h", a);
            exp_q.delete();
        end
        bus.st_req = 1'b0;
        bus.w = 1'b0; bus.h = 1'b0; bus.b = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   ok;
        bit   seen;
        logic [31:0] bad_addr [5];
        logic [2:0]  bad_whb  [5];

        bus.st_req = 1'b0; bus.w = 1'b0; bus.h = 1'b0; bus.b = 1'b0;
        bus.st_addr = 32'd0; bus.st_data = 32'd0;
        mem[32'h100] = 32'hf0f0f0f0;
        mem[32'h104] = 32'h01020304;
        mem[32'h108] = 32'h00000000;
        mem[32'h200] = 32'h00000000;
        mem[32'h300] = 32'h11111111;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_store(1'b0, 1'b0, 1'b1, 32'h103, 32'h123456AB, 0, 1'b0, lat, ok);
        chk("sb_latency", lat, 3);
        chk("sb_done", 32'(ok), 1);
        chk("sb_mem", mem[32'h100], 32'hABf0f0f0);

        mem[32'h100] = 32'hf0f0f0f0;
        do_store(1'b0, 1'b1, 1'b0, 32'h102, 32'hFFFF1234, 0, 1'b0, lat, ok);
        chk("sh_hi_latency", lat, 3);
        chk("sh_hi_mem", mem[32'h100], 32'h1234f0f0);

        mem[32'h100] = 32'hf0f0f0f0;
        do_store(1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF1234, 0, 1'b0, lat, ok);
        chk("sh_lo_mem", mem[32'h100], 32'hf0f01234);

        do_store(1'b1, 1'b0, 1'b0, 32'h100, 32'hdeadbeef, 0, 1'b0, lat, ok);
        chk("sw_latency", lat, 2);
        chk("sw_mem", mem[32'h100], 32'hdeadbeef);

        bad_addr = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h100};
        bad_whb  = '{3'b010, 3'b100, 3'b110, 3'b000, 3'b111};
        for (int i = 0; i < 5; i++) begin
            do_store(bad_whb[i][2], bad_whb[i][1], bad_whb[i][0], bad_addr[i],
                     32'h55555555, 0, 1'b0, lat, ok);
            chk("err_latency", lat, 1);
            chk("err_not_done", 32'(ok), 0);
        end
        chk("err_mem_untouched", mem[32'h100], 32'hdeadbeef);

        do_store(1'b0, 1'b0, 1'b1, 32'h200, 32'hFFFFFF11, 1, 1'b0, lat, ok);
        do_store(1'b0, 1'b0, 1'b1, 32'h201, 32'h00000022, 2, 1'b0, lat, ok);
        do_store(1'b0, 1'b0, 1'b1, 32'h202, 32'hABCDEF33, 0, 1'b0, lat, ok);
        chk("lanes_mem", mem[32'h200], 32'h00332211);
        do_store(1'b0, 1'b1, 1'b0, 32'h202, 32'h00005566, 1, 1'b0, lat, ok);
        chk("sh_wait_mem", mem[32'h200], 32'h55662211);

        do_store(1'b0, 1'b0, 1'b1, 32'h105, 32'h000000EE, 0, 1'b1, lat, ok);
        chk("tmo_latency", lat, 5);
        chk("tmo_not_done", 32'(ok), 0);
        chk("tmo_mem", mem[32'h104], 32'h01020304);

        do_store(1'b0, 1'b0, 1'b1, 32'h105, 32'h000000EE, 3, 1'b0, lat, ok);
        chk("ws3_latency", lat, 9);
        chk("ws3_done", 32'(ok), 1);
        chk("ws3_mem", mem[32'h104], 32'h0102EE04);

        do_store(1'b1, 1'b0, 1'b0, 32'h108, 32'h87654321, 4, 1'b0, lat, ok);
        chk("sw_tmo_latency", lat, 5);
        chk("sw_tmo_mem", mem[32'h108], 32'h00000000);

        // Reset in the middle of the write phase of a byte store.
        model_off = 1'b1;
        exp_q.delete();
        wait_states = 3;
        no_ack = 1'b0;
        bus.st_req = 1'b1; bus.b = 1'b1;
        bus.st_addr = 32'h301; bus.st_data = 32'h000000AA;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_reached_write", 32'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_async_busy", 32'(bus.st_busy), 0);
        chk("rst_async_mem_rd", 32'(bus.mem_rd), 0);
        bus.st_req = 1'b0; bus.b = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(bus.st_done), 0);
            chk("rst_no_err", 32'(bus.st_err), 0);
        end
        chk("rst_mem", mem[32'h300], 32'h11111111);
        @(posedge clk); #1;
        model_off = 1'b0;

        do_store(1'b1, 1'b0, 1'b0, 32'h300, 32'hCAFEF00D, 0, 1'b0, lat, ok);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_mem", mem[32'h300], 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
